// File: rtl/bus_grant_arbiter.sv
// bus_grant_arbiter: round-robin bus arbiter with bounded tenure and registered mux select
module bus_grant_arbiter #(
  parameter int               N_REQ      = 32,
  parameter int               SEL_W      = 5,
  parameter logic [N_REQ-1:0] VALID_MASK = 32'h02EF_FFFF,
  parameter int               MAX_HOLD   = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] bus_select,
  output logic             bus_valid,
  output logic             data_valid,
  output logic             preempt
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, win, idx;
  logic [7:0]       hold_q, hold_d;
  logic             preempt_q, preempt_d, dv_q, found;
  logic [N_REQ-1:0] ereq, others;
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      ptr_q     <= SEL_W'(N_REQ - 1);
      hold_q    <= '0;
      preempt_q <= 1'b0;
      dv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      preempt_q <= preempt_d;
      dv_q      <= state_q == OWN;
    end
  end
  always_comb begin
    ereq = req & VALID_MASK;
    others = ereq;
    others[sel_q] = 1'b0;
    win = '0;
    idx = '0;
    found = 1'b0;
    // Search starts just past the last winner, so the current owner is checked last.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = SEL_W'((int'(ptr_q) + i) % N_REQ);
      if (!found && ereq[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    preempt_d = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = OWN;
        sel_d = win;
        ptr_d = win;
        hold_d = 8'd1;
      end
    end else if (!ereq[sel_q] || (hold_q == 8'(MAX_HOLD) && |others)) begin
      state_d = |others ? OWN : IDLE;
      sel_d = |others ? win : sel_q;
      ptr_d = |others ? win : ptr_q;
      hold_d = |others ? 8'd1 : 8'd0;
      preempt_d = |others && ereq[sel_q];
    end else begin
      hold_d = hold_q == 8'(MAX_HOLD) ? hold_q : hold_q + 8'd1;
    end
  end
  always_comb begin
    bus_valid = state_q == OWN;
    bus_select = sel_q;
    grant = '0;
    if (bus_valid) grant[sel_q] = 1'b1;
    preempt = preempt_q;
    data_valid = dv_q;
  end
endmodule
